// File: rtl/seq_match_monitor.sv
// -----------------------------------------------------------------------------
// seq_match_monitor
//
// Purpose: watches up to three opcode streams, keeps a shift history of
// consumed codes, and pulses `hit` whenever the newest cfg_len codes equal the
// programmed sequence. Matches may overlap. In lockstep mode (mode 0) every
// channel must present a code before a step is consumed.
//
// Optional feature: define SEQMON_MISMATCH_EN to check that all lockstep codes
// agree. A disagreement pulses `mismatch` and restarts the history. Without the
// macro, lockstep mode takes channel 0's code and the mismatch outputs are 0.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   obs_valid/code    per-channel code in; channel c uses code[c*OPW +: OPW]
//   obs_ready         per-channel accept (low while that channel's hold is full)
//   mode              0 = lockstep, k = channel k-1 only, other = disabled
//   cfg_we/idx/code   sequence slot write
//   cfg_len_we/len    active sequence length write (clamped to SEQ_LEN)
//   clear_cnt         zero all counters
//   hit, hit_count    match pulse and saturating match count
//   obs_count         saturating count of consumed steps
//   mismatch(_count)  lockstep disagreement pulse and saturating count
// -----------------------------------------------------------------------------
module seq_match_monitor #(
   parameter int N_CH    = 2,
   parameter int OPW     = 4,
   parameter int SEQ_LEN = 6,
   parameter int CNT_W   = 16,
   localparam int IW     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
   localparam int LW     = $clog2(SEQ_LEN + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_CH-1:0]     obs_valid,
   input  logic [N_CH*OPW-1:0] obs_code,
   output logic [N_CH-1:0]     obs_ready,
   input  logic [1:0]          mode,
   input  logic                cfg_we,
   input  logic [IW-1:0]       cfg_idx,
   input  logic [OPW-1:0]      cfg_code,
   input  logic                cfg_len_we,
   input  logic [LW-1:0]       cfg_len,
   input  logic                clear_cnt,
   output logic                hit,
   output logic [CNT_W-1:0]    hit_count,
   output logic [CNT_W-1:0]    obs_count,
   output logic                mismatch,
   output logic [CNT_W-1:0]    mismatch_count
);

   logic [1:0]       r_mode;
   logic [N_CH-1:0]  r_held;
   logic [OPW-1:0]   r_code [N_CH];
   logic [OPW-1:0]   r_seq  [SEQ_LEN];
   logic [OPW-1:0]   r_hist [SEQ_LEN];
   logic [LW-1:0]    r_len;
   logic [LW-1:0]    r_fill;
   logic             r_hit;
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_obs_cnt;

   logic             w_flush;
   logic             w_en;
   logic             w_consume;
   logic             w_mm;
   logic             w_match;
   logic [N_CH-1:0]  w_act;
   logic [N_CH-1:0]  w_cap;
   logic [N_CH-1:0]  w_clr;
   logic [OPW-1:0]   w_sel_code;
   logic [OPW-1:0]   w_hist_nxt [SEQ_LEN];
   logic [LW-1:0]    w_fill_nxt;

   always_comb begin
      // Any reconfiguration restarts matching from an empty history.
      w_flush    = (mode != r_mode) || cfg_we || cfg_len_we;
      w_en       = (r_len != '0) && ((mode == 2'd0) || (int'(mode) <= N_CH));
      w_act      = '0;
      w_sel_code = r_code[0];
      w_consume  = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         w_act[c] = w_en && ((mode == 2'd0) || (mode == 2'(c + 1)));
         if (mode == 2'(c + 1)) begin
            w_sel_code = r_code[c];
            w_consume  = r_held[c];
         end
      end
      if (mode == 2'd0) w_consume = &r_held;
      w_consume = w_consume && w_en && !w_flush;

      // Inactive channels always accept and drop their input.
      for (int c = 0; c < N_CH; c++) begin
         obs_ready[c] = w_act[c] ? !r_held[c] : 1'b1;
         w_cap[c]     = w_act[c] && !w_flush && obs_valid[c] && !r_held[c];
      end
      w_clr = w_consume ? w_act : '0;

      for (int i = 0; i < SEQ_LEN; i++) w_hist_nxt[i] = r_hist[i];
      w_fill_nxt = r_fill;
      if (w_flush || w_mm) begin
         for (int i = 0; i < SEQ_LEN; i++) w_hist_nxt[i] = '0;
         w_fill_nxt = '0;
      end else if (w_consume) begin
         w_hist_nxt[0] = w_sel_code;
         for (int i = 1; i < SEQ_LEN; i++) w_hist_nxt[i] = r_hist[i-1];
         if (int'(r_fill) < SEQ_LEN) w_fill_nxt = r_fill + LW'(1);
      end

      // history[i] must equal seq[len-1-i]; pair (i,j) is compared when i+j == len-1.
      w_match = (r_len != '0) && (w_fill_nxt >= r_len);
      for (int i = 0; i < SEQ_LEN; i++)
         for (int j = 0; j < SEQ_LEN; j++)
            if ((i + j == int'(r_len) - 1) && (w_hist_nxt[i] != r_seq[j]))
               w_match = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode    <= '0;
         r_held    <= '0;
         r_len     <= '0;
         r_fill    <= '0;
         r_hit     <= 1'b0;
         r_hit_cnt <= '0;
         r_obs_cnt <= '0;
         for (int c = 0; c < N_CH; c++) r_code[c] <= '0;
         for (int i = 0; i < SEQ_LEN; i++) begin
            r_seq[i]  <= '0;
            r_hist[i] <= '0;
         end
      end else begin
         r_mode <= mode;
         if (cfg_we && (int'(cfg_idx) < SEQ_LEN)) r_seq[cfg_idx] <= cfg_code;
         if (cfg_len_we) r_len <= (int'(cfg_len) > SEQ_LEN) ? LW'(SEQ_LEN) : cfg_len;

         r_held <= w_flush ? '0 : ((r_held & ~w_clr) | w_cap);
         for (int c = 0; c < N_CH; c++)
            if (w_cap[c]) r_code[c] <= obs_code[c*OPW +: OPW];
         for (int i = 0; i < SEQ_LEN; i++) r_hist[i] <= w_hist_nxt[i];
         r_fill <= w_fill_nxt;

         r_hit <= w_consume && !w_mm && w_match;

         // The hit counter advances at the end of the hit pulse, so a
         // clear_cnt during the pulse wins over that increment.
         if (clear_cnt) begin
            r_hit_cnt <= '0;
            r_obs_cnt <= '0;
         end else begin
            if (r_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            if (w_consume && (r_obs_cnt != '1)) r_obs_cnt <= r_obs_cnt + CNT_W'(1);
         end
      end
   end

   assign hit       = r_hit;
   assign hit_count = r_hit_cnt;
   assign obs_count = r_obs_cnt;

`ifdef SEQMON_MISMATCH_EN
   logic             w_all_eq;
   logic             r_mm;
   logic [CNT_W-1:0] r_mm_cnt;

   always_comb begin
      w_all_eq = 1'b1;
      for (int c = 1; c < N_CH; c++)
         if (r_code[c] != r_code[0]) w_all_eq = 1'b0;
      w_mm = w_consume && (mode == 2'd0) && !w_all_eq;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mm     <= 1'b0;
         r_mm_cnt <= '0;
      end else begin
         r_mm <= w_mm;
         if (clear_cnt) r_mm_cnt <= '0;
         else if (r_mm && (r_mm_cnt != '1)) r_mm_cnt <= r_mm_cnt + CNT_W'(1);
      end
   end

   assign mismatch       = r_mm;
   assign mismatch_count = r_mm_cnt;
`else
   assign w_mm           = 1'b0;
   assign mismatch       = 1'b0;
   assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_seq_match_monitor.sv
module tb_seq_match_monitor;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  obs_valid;
   logic [7:0]  obs_code;
   logic [1:0]  mode;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic [3:0]  cfg_code;
   logic        cfg_len_we;
   logic [2:0]  cfg_len;
   logic        clear_cnt;

   logic [1:0]  obs_ready, obs_ready2;
   logic        hit, hit2, mismatch, mismatch2;
   logic [15:0] hit_count, obs_count, mismatch_count;
   logic [1:0]  hc2, oc2, mmc2;

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] seq6 [6] = '{4'hE, 4'h1, 4'h1, 4'h3, 4'hF, 4'h5};

   seq_match_monitor dut (
      .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_code(obs_code),
      .obs_ready(obs_ready), .mode(mode), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_code(cfg_code), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
      .clear_cnt(clear_cnt), .hit(hit), .hit_count(hit_count),
      .obs_count(obs_count), .mismatch(mismatch), .mismatch_count(mismatch_count)
   );

   // Narrow-counter copy sharing all stimulus, for saturation checks.
   seq_match_monitor #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_code(obs_code),
      .obs_ready(obs_ready2), .mode(mode), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_code(cfg_code), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
      .clear_cnt(clear_cnt), .hit(hit2), .hit_count(hc2),
      .obs_count(oc2), .mismatch(mismatch2), .mismatch_count(mmc2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_slot(input int idx, input logic [3:0] c);
      cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_code = c;
      tick;
      cfg_we = 1'b0;
   endtask

   task automatic set_len(input int l);
      cfg_len_we = 1'b1; cfg_len = 3'(l);
      tick;
      cfg_len_we = 1'b0;
   endtask

   task automatic send(input int ch, input logic [3:0] c);
      int b;
      b = 0;
      obs_code[ch*4 +: 4] = c;
      obs_valid[ch] = 1'b1;
      while (!obs_ready[ch] && b < 20) begin
         tick;
         b++;
      end
      if (b >= 20) begin
         n_chk++;
         n_fail++;
         $error("FAIL send_timeout ch=%0d observed=ready0 expected=ready1", ch);
      end
      tick;
      obs_valid[ch] = 1'b0;
   endtask

   task automatic send2(input logic [3:0] c0, input logic [3:0] c1);
      int b;
      b = 0;
      obs_code  = {c1, c0};
      obs_valid = 2'b11;
      while (obs_ready != 2'b11 && b < 20) begin
         tick;
         b++;
      end
      if (b >= 20) begin
         n_chk++;
         n_fail++;
         $error("FAIL send2_timeout observed=%0b expected=11", obs_ready);
      end
      tick;
      obs_valid = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; obs_valid = '0; obs_code = '0; mode = 2'd0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_code = '0; cfg_len_we = 1'b0;
      cfg_len = '0; clear_cnt = 1'b0;
      tick; tick;
      chk("rst_hit", hit, 0);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_obs_count", obs_count, 0);
      chk("rst_ready", obs_ready, 2'b11);
      chk("rst_mismatch", mismatch, 0);
      reset = 1'b0;

      // Mode 2: full six-code sequence on channel 1.
      mode = 2'd2;
      for (int i = 0; i < 6; i++) write_slot(i, seq6[i]);
      set_len(6);
      for (int i = 0; i < 5; i++) begin
         send(1, seq6[i]);
         if (i == 0) chk("m2_ready_unsel", obs_ready, 2'b01);
         chk("m2_no_early_hit", hit, 0);
      end
      send(1, seq6[5]);
      chk("m2_hit_lat1", hit, 0);
      tick;
      chk("m2_hit_lat2", hit, 1);
      tick;
      chk("m2_hit_one_cycle", hit, 0);
      chk("m2_hit_count", hit_count, 1);
      chk("m2_obs_count", obs_count, 6);
      chk("m2_obs_count_sat", oc2, 3);

      // Mode 1: seq {1,1}, overlapping matches.
      clear_cnt = 1'b1;
      mode = 2'd1;
      tick;
      clear_cnt = 1'b0;
      chk("clr_hit_count", hit_count, 0);
      chk("clr_obs_count", obs_count, 0);
      write_slot(0, 4'h1);
      write_slot(1, 4'h1);
      set_len(2);
      send(0, 4'h1);
      send(0, 4'h1);
      chk("m1_pre_hit", hit, 0);
      tick;
      chk("m1_hit1", hit, 1);
      send(0, 4'h1);
      chk("m1_count1", hit_count, 1);
      tick;
      chk("m1_hit2_overlap", hit, 1);
      tick;
      chk("m1_count2", hit_count, 2);

      // Three more hits: five total, narrow counter saturates.
      repeat (3) begin
         send(0, 4'h1);
         tick;
      end
      chk("sat_hit5", hit, 1);
      tick;
      chk("sat_wide_count", hit_count, 5);
      chk("sat_narrow_count", hc2, 3);

      // clear_cnt during a hit pulse wins over its increment.
      send(0, 4'h1);
      tick;
      chk("clr_prio_hit", hit, 1);
      clear_cnt = 1'b1;
      tick;
      clear_cnt = 1'b0;
      chk("clr_prio_wide", hit_count, 0);
      chk("clr_prio_narrow", hc2, 0);

      // Disabled mode: inputs accepted and dropped.
      mode = 2'd3;
      tick;
      chk("dis_ready", obs_ready, 2'b11);
      send(0, 4'h9);
      send(1, 4'h9);
      tick; tick;
      chk("dis_obs_count", obs_count, 0);
      chk("dis_hit", hit, 0);

      // Mode 0 lockstep: ch0=3 waits for ch1=5.
      mode = 2'd0;
      write_slot(0, 4'h3);
      write_slot(1, 4'h3);
      set_len(2);
      send(0, 4'h3);
      chk("m0_wait_ready_a", obs_ready, 2'b10);
      repeat (4) tick;
      chk("m0_wait_ready_b", obs_ready, 2'b10);
      chk("m0_wait_no_consume", obs_count, 0);
      send(1, 4'h5);
      chk("m0_mm_pre", mismatch, 0);
      tick;
`ifdef SEQMON_MISMATCH_EN
      chk("m0_mm_pulse", mismatch, 1);
`else
      chk("m0_mm_tied", mismatch, 0);
`endif
      tick;
      chk("m0_mm_one_cycle", mismatch, 0);
`ifdef SEQMON_MISMATCH_EN
      chk("m0_mm_count", mismatch_count, 1);
`else
      chk("m0_mm_count_tied", mismatch_count, 0);
`endif
      send2(4'h3, 4'h3);
      tick;
`ifdef SEQMON_MISMATCH_EN
      chk("m0_no_shift_after_mm", hit, 0);
`else
      chk("m0_ch0_code_used", hit, 1);
`endif
      send2(4'h3, 4'h3);
      tick;
      chk("m0_pair_hit", hit, 1);

      // Reset mid-sequence discards progress.
      mode = 2'd2;
      for (int i = 0; i < 6; i++) write_slot(i, seq6[i]);
      set_len(6);
      for (int i = 0; i < 3; i++) send(1, seq6[i]);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("mid_rst_hit_count", hit_count, 0);
      chk("mid_rst_obs_count", obs_count, 0);
      chk("mid_rst_ready", obs_ready, 2'b11);
      for (int i = 0; i < 6; i++) write_slot(i, seq6[i]);
      write_slot(6, 4'h0);
      write_slot(7, 4'h0);
      set_len(7);
      for (int i = 0; i < 5; i++) begin
         send(1, seq6[i]);
         chk("mid_rst_no_spurious", hit, 0);
      end
      send(1, seq6[5]);
      tick;
      chk("mid_rst_full_hit", hit, 1);
      tick;
      chk("mid_rst_hit_count1", hit_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_match_monitor.md
SEQ_MATCH_MONITOR -- requirements
Module: seq_match_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of observation channels (legal range 1..3).
REQ-002 SHALL have parameter OPW, default 4, opcode code width in bits.
REQ-003 SHALL have parameter SEQ_LEN, default 6, maximum programmable sequence length.
REQ-004 SHALL have parameter CNT_W, default 16, counter width.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- obs_valid  in  N_CH  per-channel code valid.
- obs_code  in  N_CH*OPW  per-channel code; channel c occupies bits [c*OPW +: OPW].
- obs_ready  out  N_CH  per-channel accept.
- mode  in  2  0 = lockstep all channels; k in 1..N_CH = channel k-1 only; any other value = disabled.
- cfg_we  in  1  sequence write strobe.
- cfg_idx  in  clog2(SEQ_LEN)  sequence slot.
- cfg_code  in  OPW  slot value.
- cfg_len_we  in  1  length write strobe.
- cfg_len  in  clog2(SEQ_LEN+1)  active length.
- clear_cnt  in  1  counter clear.
- hit  out  1  one-cycle match pulse.
- hit_count  out  CNT_W  saturating match count.
- obs_count  out  CNT_W  saturating consumed-step count.
- mismatch  out  1  one-cycle lockstep disagreement pulse.
- mismatch_count  out  CNT_W  saturating mismatch count.

Function
REQ-006 SHALL give each channel a one-entry hold register; obs_ready[c] = !held[c]; obs_valid[c] && obs_ready[c] captures the code and sets held[c] at the next edge.
REQ-007 In single-channel modes, SHALL consume the selected channel's held entry in the cycle after capture; unselected channels SHALL assert obs_ready=1 and discard their input.
REQ-008 In mode 0, SHALL consume when every channel is held; a partially held set SHALL wait indefinitely; held channels SHALL keep obs_ready=0.
REQ-009 On consumption, SHALL clear all consumed holds, shift the code into a SEQ_LEN-deep history (newest at slot 0), increment fill (saturating at SEQ_LEN), and increment obs_count.
REQ-010 SHALL assert hit for one cycle, the cycle after consumption, iff cfg_len != 0, fill >= cfg_len, and history[i] == seq[cfg_len-1-i] for all i < cfg_len; hit latency from the final accepting handshake is 2 cycles.
REQ-011 Matches SHALL be overlapping: a hit SHALL NOT flush history.
REQ-012 Disabled mode or cfg_len == 0 SHALL produce no hit, no consumption, and obs_ready = all ones (inputs dropped).
REQ-013 A change of mode versus its registered value, or cfg_we or cfg_len_we asserted, SHALL clear all holds, the history, and fill in that cycle; counters SHALL be kept.
REQ-014 Counters SHALL saturate at all-ones; clear_cnt SHALL zero all counters and take priority over a same-cycle increment.
REQ-015 cfg_idx >= SEQ_LEN SHALL be ignored; cfg_len > SEQ_LEN SHALL be clamped to SEQ_LEN.

Reset
REQ-016 reset SHALL clear holds (obs_ready = all ones), history, fill, all sequence slots, cfg_len (matching disabled), registered mode, and every counter, and drive hit=0 and mismatch=0; reset asserted mid-sequence SHALL discard partial progress.

Configuration
REQ-017 With SEQMON_MISMATCH_EN defined, a mode-0 consumption whose held codes are not all equal SHALL pulse mismatch the next cycle, increment mismatch_count, shift nothing, and clear history and fill.
REQ-018 Without SEQMON_MISMATCH_EN, mode 0 SHALL consume channel 0's code without comparison, and mismatch and mismatch_count SHALL be tied to 0.

Verification
REQ-019 Directed scenarios:
- Mode 2, cfg seq {E,1,1,3,F,5} with cfg_len 6; feed E,1,1,3,F,5 on channel 1 -> exactly one hit, 2 cycles after the last handshake; hit_count=1, obs_count=6.
- Mode 1, seq {1,1} with cfg_len 2; feed 1,1,1 -> 2 hits; hit_count=2.
- Mode 0 with SEQMON_MISMATCH_EN; ch0=3 and ch1=5 arrive 4 cycles apart -> ch0 obs_ready low while waiting, then one mismatch pulse, mismatch_count=1, no shift.
- CNT_W=2; 5 hits -> hit_count=3; clear_cnt in the same cycle as a hit -> hit_count=0.
- reset asserted after E,1,1 of the 6-code sequence, then cfg rewritten and full sequence fed -> no spurious hit; hit_count=1 only after the complete 6 codes.
